// File: rtl/toggle_pulse_gen_pkg.sv
// toggle_pulse_gen_pkg: state encoding and default timing for the button-to-toggle front end
package toggle_pulse_gen_pkg;
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES     = 64;
    localparam int DEF_REPEAT_CYCLES   = 16;
    localparam int PRESS_CNT_W         = 8;
endpackage

// File: rtl/toggle_pulse_gen_sync_chain.sv
// sync_chain: multi-flop synchroniser for one asynchronous level input
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk) ff <= rst ? '0 : {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: synchronise and debounce a button into single-cycle toggle pulses with optional auto-repeat
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_in,
    output logic                   t_pulse,
    output logic                   btn_level,
    output logic [PRESS_CNT_W-1:0] press_cnt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    logic          s;
    state_t        state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          press_ev, rep_ev, rel_ev;
    logic          press_q, rep_q, rel_q;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(s));

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        rep_nxt   = rep_cnt;
        press_ev  = 1'b0;
        rep_ev    = 1'b0;
        rel_ev    = 1'b0;
        case (state)
            IDLE: if (s) begin
                state_nxt = PRESS_WAIT;
                deb_nxt   = DW'(1);
            end
            PRESS_WAIT: if (!s) begin
                state_nxt = IDLE;
                deb_nxt   = '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                state_nxt = PRESSED;
                deb_nxt   = '0;
                hold_nxt  = '0;
                press_ev  = 1'b1;
            end else deb_nxt = deb_cnt + 1'b1;
            PRESSED: if (!s) begin
                state_nxt = RELEASE_WAIT;
                deb_nxt   = DW'(1);
            end else if (REPEAT_EN != 0 && hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                state_nxt = REPEAT;
                rep_nxt   = '0;
                rep_ev    = 1'b1;
            end else if (hold_cnt != HW'(HOLD_CYCLES - 1)) hold_nxt = hold_cnt + 1'b1;
            REPEAT: if (!s) begin
                state_nxt = RELEASE_WAIT;
                deb_nxt   = DW'(1);
            end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                rep_nxt = '0;
                rep_ev  = 1'b1;
            end else rep_nxt = rep_cnt + 1'b1;
            RELEASE_WAIT: if (s) begin
                state_nxt = PRESSED;
                deb_nxt   = '0;
                hold_nxt  = '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                rel_ev    = 1'b1;
            end else deb_nxt = deb_cnt + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // events are staged one cycle so outputs land the cycle after the state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            rep_q     <= 1'b0;
            rel_q     <= 1'b0;
            t_pulse   <= 1'b0;
            btn_level <= 1'b0;
            press_cnt <= '0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            rep_cnt   <= rep_nxt;
            press_q   <= press_ev;
            rep_q     <= rep_ev;
            rel_q     <= rel_ev;
            t_pulse   <= press_q | rep_q;
            btn_level <= press_q | (btn_level & ~rel_q);
            press_cnt <= press_cnt + PRESS_CNT_W'(press_q);
        end
    end
endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb_toggle_pulse_gen: scoreboard bench, u0 without auto-repeat and u1 with auto-repeat
module tb_toggle_pulse_gen;
    logic       clk = 1'b0, rst = 1'b1, btn0 = 1'b0, btn1 = 1'b0;
    logic       tp0, tp1, bl0, bl1;
    logic [7:0] pc0, pc1;
    int         cyc = 0, vectors = 0, miscompares = 0, pulses0 = 0;
    logic       q0 = 1'b0, qs = 1'b0, prev0 = 1'b0, prev1 = 1'b0;
    int         exp0[$], exp1[$];

    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .HOLD_CYCLES(10), .REPEAT_CYCLES(5))
        u0 (.clk(clk), .rst(rst), .btn_in(btn0), .t_pulse(tp0), .btn_level(bl0), .press_cnt(pc0));
    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(5))
        u1 (.clk(clk), .rst(rst), .btn_in(btn1), .t_pulse(tp1), .btn_level(bl1), .press_cnt(pc1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        int e;
        cyc++;
        #1;
        if (tp0) begin
            e = -1;
            if (exp0.size() != 0) e = exp0.pop_front();
            chk("u0_pulse_cycle", cyc, e);
            chk("u0_pulse_width", prev0, 0);
            chk("u0_level_with_pulse", bl0, 1);
            pulses0++;
            q0 = ~q0;
        end
        if (tp1) begin
            e = -1;
            if (exp1.size() != 0) e = exp1.pop_front();
            chk("u1_pulse_cycle", cyc, e);
            chk("u1_pulse_width", prev1, 0);
            chk("u1_level_with_pulse", bl1, 1);
        end
        prev0 = tp0;
        prev1 = tp1;
    end

    initial begin
        int c;
        logic [7:0] bnc;
        tick(3);
        chk("rst_tp0", tp0, 0);
        chk("rst_bl0", bl0, 0);
        chk("rst_pc0", pc0, 0);
        chk("rst_tp1", tp1, 0);
        chk("rst_bl1", bl1, 0);
        chk("rst_pc1", pc1, 0);
        rst = 1'b0;
        tick(2);
        // clean press without repeat
        c = cyc;
        btn0 = 1'b1;
        exp0.push_back(c + 7);
        tick(6);
        chk("t1_level_before", bl0, 0);
        tick(1);
        chk("t1_level", bl0, 1);
        chk("t1_press_cnt", pc0, 1);
        tick(33);
        btn0 = 1'b0;
        tick(10);
        chk("t1_level_released", bl0, 0);
        chk("t1_drain", exp0.size(), 0);
        // bouncing press: 1,1,0,1,1,1,0,1 then steady high
        bnc = 8'b1011_1011;
        for (int i = 0; i < 8; i++) begin
            btn0 = bnc[i];
            if (i == 7) exp0.push_back(cyc + 7);
            tick(1);
        end
        tick(20);
        chk("t2_press_cnt", pc0, 2);
        btn0 = 1'b0;
        tick(10);
        chk("t2_drain", exp0.size(), 0);
        // auto-repeat
        c = cyc;
        btn1 = 1'b1;
        exp1.push_back(c + 7);
        for (int t = c + 17; t <= c + 42; t += 5) exp1.push_back(t);
        tick(40);
        btn1 = 1'b0;
        tick(12);
        chk("t3_press_cnt", pc1, 1);
        chk("t3_level_released", bl1, 0);
        chk("t3_drain", exp1.size(), 0);
        // release glitch restarts the hold counter, level stays high
        c = cyc;
        btn1 = 1'b1;
        exp1.push_back(c + 7);
        exp1.push_back(c + 28);
        exp1.push_back(c + 33);
        exp1.push_back(c + 38);
        exp1.push_back(c + 43);
        tick(12);
        btn1 = 1'b0;
        tick(2);
        btn1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t4_level_held", bl1, 1);
        end
        tick(6);
        btn1 = 1'b0;
        tick(12);
        chk("t4_press_cnt", pc1, 2);
        chk("t4_drain", exp1.size(), 0);
        // 256 presses wrap press_cnt; TFF driven by t_pulse returns to its start
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pulses0 = 0;
        qs = q0;
        for (int i = 0; i < 256; i++) begin
            btn0 = 1'b1;
            exp0.push_back(cyc + 7);
            tick(10);
            btn0 = 1'b0;
            tick(10);
            if (i == 254) chk("t5_press_cnt_255", pc0, 255);
        end
        chk("t5_press_cnt_wrap", pc0, 0);
        chk("t5_pulse_count", pulses0, 256);
        chk("t5_tff_q", q0, qs);
        chk("t5_drain", exp0.size(), 0);
        // reset while repeating with the button still held
        c = cyc;
        btn1 = 1'b1;
        exp1.push_back(c + 7);
        exp1.push_back(c + 17);
        exp1.push_back(c + 22);
        tick(24);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_tp_after_rst", tp1, 0);
        chk("t6_bl_after_rst", bl1, 0);
        chk("t6_pc_after_rst", pc1, 0);
        exp1.push_back(cyc + 7);
        tick(12);
        btn1 = 1'b0;
        tick(12);
        chk("t6_press_cnt", pc1, 1);
        chk("t6_level_released", bl1, 0);
        chk("t6_drain", exp1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
